// File: rtl/dm_axi_master.sv
// Data-side AXI4 master bridge: turns single-word MEM-stage loads/stores into
// single-beat AXI4 read/write transactions and stalls the pipeline meanwhile.
module dm_axi_master #(
  parameter int unsigned     ID_W      = 4,
  parameter int unsigned     LEN_W     = 4,
  parameter logic [ID_W-1:0] MASTER_ID = ID_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [31:0]       Data_addr,
  input  logic [31:0]       Data_out,
  input  logic [31:0]       DM_BWEB,
  input  logic              IM_stall,
  output logic [31:0]       Data_in,
  output logic              DM_stall,
  output logic              bus_err,
  output logic [ID_W-1:0]   ARID,
  output logic [31:0]       ARADDR,
  output logic [LEN_W-1:0]  ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ID_W-1:0]   AWID,
  output logic [31:0]       AWADDR,
  output logic [LEN_W-1:0]  AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [31:0]       WDATA,
  output logic [3:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_data_in;
  logic        r_bus_err;
  logic        w_req;
  logic        w_capture;
  logic        w_rd_fire;
  logic        w_err_set;
  logic        w_unused;

  assign w_req     = MEM_MemRead | MEM_MemWrite;
  assign w_capture = (r_state == S_IDLE) && w_req;
  assign w_rd_fire = (r_state == S_R) && RVALID;
  assign w_err_set = (w_rd_fire && (RRESP != 2'b00)) ||
                     ((r_state == S_B) && BVALID && (BRESP != 2'b00));

  // Single-beat, full-word, INCR bursts with a fixed ID
  assign ARID    = MASTER_ID;
  assign ARLEN   = LEN_W'(0);
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign AWID    = MASTER_ID;
  assign AWLEN   = LEN_W'(0);
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign WLAST   = 1'b1;
  assign ARADDR  = r_addr;
  assign AWADDR  = r_addr;
  assign WDATA   = r_wdata;
  assign WSTRB   = r_wstrb;
  assign Data_in = r_data_in;
  assign bus_err = r_bus_err;

  // Response IDs/RLAST carry no information for single-beat, single-ID traffic
  assign w_unused = ^{RID, RLAST, BID, DM_BWEB};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and channel handshake decode; VALIDs depend on state only
  always_comb begin
    w_next   = r_state;
    ARVALID  = 1'b0;
    RREADY   = 1'b0;
    AWVALID  = 1'b0;
    WVALID   = 1'b0;
    BREADY   = 1'b0;
    DM_stall = 1'b1;
    case (r_state)
      S_IDLE: begin
        DM_stall = w_req;
        if (MEM_MemWrite)     w_next = S_AW;
        else if (MEM_MemRead) w_next = S_AR;
      end
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) w_next = S_R;
      end
      S_R: begin
        RREADY = 1'b1;
        if (RVALID) w_next = S_DONE;
      end
      S_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) w_next = S_W;
      end
      S_W: begin
        WVALID = 1'b1;
        if (WREADY) w_next = S_B;
      end
      S_B: begin
        BREADY = 1'b1;
        if (BVALID) w_next = S_DONE;
      end
      S_DONE: begin
        DM_stall = 1'b0;
        if (!IM_stall) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture in IDLE; strobe bit i follows the byte's lowest BWEB bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_capture) begin
      r_addr  <= Data_addr;
      r_wdata <= Data_out;
      r_wstrb <= {~DM_BWEB[24], ~DM_BWEB[16], ~DM_BWEB[8], ~DM_BWEB[0]};
    end
  end

  // Load data is updated only on the R handshake edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_data_in <= '0;
    else if (w_rd_fire) r_data_in <= RDATA;
  end

  // Error pulse lands exactly in the first DONE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_bus_err <= 1'b0;
    else      r_bus_err <= w_err_set;
  end

endmodule

// File: tb/tb_dm_axi_master.sv
// Self-checking bench for dm_axi_master: per-cycle expectation traces built
// from transaction latencies, plus literal checks on handshake/stall counts.
module tb_dm_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_MemRead, MEM_MemWrite, IM_stall;
  logic [31:0] Data_addr, Data_out, DM_BWEB, Data_in;
  logic        DM_stall, bus_err;
  logic [3:0]  ARID, AWID, RID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [3:0]  ARLEN, AWLEN, WSTRB;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  always #5 clk = ~clk;

  dm_axi_master dut (
    .clk(clk), .rst(rst), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .Data_addr(Data_addr), .Data_out(Data_out), .DM_BWEB(DM_BWEB), .IM_stall(IM_stall),
    .Data_in(Data_in), .DM_stall(DM_stall), .bus_err(bus_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  // One cycle of stimulus plus the outputs that cycle must show
  typedef struct {
    logic        rd, wr, im, arready, rvalid, awready, wready, bvalid;
    logic [31:0] addr, wdata, bweb, rdata;
    logic [1:0]  rresp, bresp;
    logic        stall, arv, rrdy, awv, wv, brdy, berr;
    logic [3:0]  wstrb;
    logic [31:0] data_in;
  } cyc_t;

  cyc_t        q[$];
  cyc_t        cur;
  logic        chk_en = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_data_in = '0;
  int          st_cyc, st_stall, st_ar_hs, st_aw_hs, st_berr, st_first_low;
  logic [3:0]  st_wstrb;
  logic [31:0] st_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] strb_of(input logic [31:0] bweb);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = ~bweb[8*i];
    return s;
  endfunction

  function automatic cyc_t base();
    cyc_t c;
    c = '{default: '0};
    c.bweb    = '1;
    c.data_in = m_data_in;
    return c;
  endfunction

  function automatic cyc_t req_cyc(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] bweb);
    cyc_t c;
    c = base();
    c.rd = rd; c.wr = wr; c.addr = addr; c.wdata = wdata; c.bweb = bweb;
    c.stall = 1'b1;
    return c;
  endfunction

  // Load: IDLE, AR for wa+1 cycles, R for wr+1 cycles, DONE for h+1 cycles, then idle
  function automatic void add_load(input logic [31:0] addr, input logic [31:0] rdata,
                                   input logic [1:0] resp, input int wa, input int wr, input int h);
    cyc_t c;
    q.push_back(req_cyc(1'b1, 1'b0, addr, 32'h0, '1));
    for (int i = 0; i <= wa; i++) begin
      c = req_cyc(1'b1, 1'b0, addr, 32'h0, '1);
      c.arv = 1'b1; c.arready = (i == wa);
      q.push_back(c);
    end
    for (int i = 0; i <= wr; i++) begin
      c = req_cyc(1'b1, 1'b0, addr, 32'h0, '1);
      c.rrdy = 1'b1; c.rvalid = (i == wr);
      c.rdata = (i == wr) ? rdata : ~rdata;
      c.rresp = (i == wr) ? resp : 2'b00;
      q.push_back(c);
    end
    m_data_in = rdata;
    for (int i = 0; i <= h; i++) begin
      c = req_cyc(1'b1, 1'b0, addr, 32'h0, '1);
      c.stall = 1'b0; c.im = (i < h);
      c.berr  = (i == 0) && (resp != 2'b00);
      q.push_back(c);
    end
    q.push_back(base());
  endfunction

  // Store: IDLE, AW, W, B with the given wait cycles, DONE for h+1 cycles, then idle
  function automatic void add_store(input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] bweb, input logic [1:0] resp,
                                    input int waw, input int ww, input int wb, input int h,
                                    input logic both);
    cyc_t c;
    q.push_back(req_cyc(both, 1'b1, addr, wdata, bweb));
    for (int i = 0; i <= waw; i++) begin
      c = req_cyc(both, 1'b1, addr, wdata, bweb);
      c.awv = 1'b1; c.awready = (i == waw);
      q.push_back(c);
    end
    for (int i = 0; i <= ww; i++) begin
      c = req_cyc(both, 1'b1, addr, wdata, bweb);
      c.wv = 1'b1; c.wready = (i == ww); c.wstrb = strb_of(bweb);
      q.push_back(c);
    end
    for (int i = 0; i <= wb; i++) begin
      c = req_cyc(both, 1'b1, addr, wdata, bweb);
      c.brdy = 1'b1; c.bvalid = (i == wb);
      c.bresp = (i == wb) ? resp : 2'b00;
      q.push_back(c);
    end
    for (int i = 0; i <= h; i++) begin
      c = req_cyc(both, 1'b1, addr, wdata, bweb);
      c.stall = 1'b0; c.im = (i < h);
      c.berr  = (i == 0) && (resp != 2'b00);
      q.push_back(c);
    end
    q.push_back(base());
  endfunction

  task automatic apply(input cyc_t c);
    MEM_MemRead = c.rd; MEM_MemWrite = c.wr; IM_stall = c.im;
    Data_addr = c.addr; Data_out = c.wdata; DM_BWEB = c.bweb;
    ARREADY = c.arready; RVALID = c.rvalid; RDATA = c.rdata; RRESP = c.rresp;
    AWREADY = c.awready; WREADY = c.wready; BVALID = c.bvalid; BRESP = c.bresp;
  endtask

  // Play the queued trace one cycle at a time; inputs change 1 time unit after posedge
  task automatic run_q(input bit tail_idle);
    st_cyc = 0; st_stall = 0; st_ar_hs = 0; st_aw_hs = 0; st_berr = 0;
    st_first_low = -1; st_wstrb = '0; st_data = '0;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      apply(q[i]);
      cur    = q[i];
      chk_en = 1'b1;
    end
    if (tail_idle) begin
      @(posedge clk); #1;
      chk_en = 1'b0;
      apply(base());
    end
    q.delete();
  endtask

  // Compare every checked cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("DM_stall", 32'(DM_stall), 32'(cur.stall));
      chk("ARVALID",  32'(ARVALID),  32'(cur.arv));
      chk("RREADY",   32'(RREADY),   32'(cur.rrdy));
      chk("AWVALID",  32'(AWVALID),  32'(cur.awv));
      chk("WVALID",   32'(WVALID),   32'(cur.wv));
      chk("BREADY",   32'(BREADY),   32'(cur.brdy));
      chk("Data_in",  Data_in,       cur.data_in);
      chk("bus_err",  32'(bus_err),  32'(cur.berr));
      if (cur.arv) begin
        chk("ARADDR", ARADDR, cur.addr);
        chk("ARID",   32'(ARID), 32'd1);
        chk("ARLEN",  32'(ARLEN), 32'd0);
        chk("ARSIZE", 32'(ARSIZE), 32'd2);
        chk("ARBURST", 32'(ARBURST), 32'd1);
      end
      if (cur.awv) begin
        chk("AWADDR", AWADDR, cur.addr);
        chk("AWID",   32'(AWID), 32'd1);
        chk("AWLEN",  32'(AWLEN), 32'd0);
        chk("AWSIZE", 32'(AWSIZE), 32'd2);
        chk("AWBURST", 32'(AWBURST), 32'd1);
      end
      if (cur.wv) begin
        chk("WDATA", WDATA, cur.wdata);
        chk("WSTRB", 32'(WSTRB), 32'(cur.wstrb));
        chk("WLAST", 32'(WLAST), 32'd1);
      end
      if (DM_stall) st_stall++;
      else if (st_first_low < 0) st_first_low = st_cyc;
      if (ARVALID && ARREADY) st_ar_hs++;
      if (AWVALID && AWREADY) st_aw_hs++;
      if (bus_err) st_berr++;
      if (WVALID) st_wstrb = WSTRB;
      st_data = Data_in;
      st_cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RID = 4'd1; BID = 4'd1; RLAST = 1'b1;
    rst = 1'b0;
    apply(base());
    #12;
    chk("rst_DM_stall", 32'(DM_stall), 32'd0);
    chk("rst_valids", 32'({ARVALID, AWVALID, WVALID}), 32'd0);
    chk("rst_readys", 32'({RREADY, BREADY}), 32'd0);
    chk("rst_Data_in", Data_in, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Basic load
    add_load(32'h0001_0004, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    run_q(1'b1);
    chk("load_model_data", m_data_in, 32'hDEAD_BEEF);
    chk("load_stall_cycles", 32'(st_stall), 32'd3);
    chk("load_first_done", 32'(st_first_low), 32'd3);
    chk("load_ar_hs", 32'(st_ar_hs), 32'd1);
    chk("load_Data_in", st_data, 32'hDEAD_BEEF);

    // Basic store; load data must survive it
    add_store(32'h0002_0008, 32'h1234_5678, 32'hFFFF_0000, 2'b00, 0, 0, 0, 0, 1'b0);
    run_q(1'b1);
    chk("store_stall_cycles", 32'(st_stall), 32'd4);
    chk("store_first_done", 32'(st_first_low), 32'd4);
    chk("store_wstrb", 32'(st_wstrb), 32'(4'b0011));
    chk("store_aw_hs", 32'(st_aw_hs), 32'd1);
    chk("store_keeps_Data_in", st_data, 32'hDEAD_BEEF);

    // AR backpressure for 5 cycles, R delayed by 2
    add_load(32'h0001_0100, 32'hCAFE_F00D, 2'b00, 5, 2, 0);
    run_q(1'b1);
    chk("bp_ar_hs", 32'(st_ar_hs), 32'd1);
    chk("bp_stall_cycles", 32'(st_stall), 32'd10);

    // DONE held by IM_stall for 3 cycles, with an error response
    add_load(32'h0000_0040, 32'h1122_3344, 2'b11, 0, 0, 3);
    run_q(1'b1);
    chk("hold_berr_width", 32'(st_berr), 32'd1);
    chk("hold_ar_hs", 32'(st_ar_hs), 32'd1);
    chk("hold_stall_cycles", 32'(st_stall), 32'd3);
    chk("hold_Data_in", st_data, 32'h1122_3344);

    // Store with SLVERR and waits on every channel
    add_store(32'h0003_0010, 32'h0BAD_F00D, 32'h0000_0000, 2'b10, 1, 2, 1, 0, 1'b0);
    run_q(1'b1);
    chk("err_berr_width", 32'(st_berr), 32'd1);
    chk("err_stall_cycles", 32'(st_stall), 32'd8);
    chk("err_wstrb", 32'(st_wstrb), 32'(4'b1111));

    // Both requests high: the write wins
    add_store(32'h0004_0000, 32'hA1B2_C3D4, 32'h00FF_00FF, 2'b00, 0, 0, 0, 1, 1'b1);
    run_q(1'b1);
    chk("both_wstrb", 32'(st_wstrb), 32'(4'b1010));
    chk("both_ar_hs", 32'(st_ar_hs), 32'd0);
    chk("both_aw_hs", 32'(st_aw_hs), 32'd1);

    // Reset while in W: abandon the store
    begin
      cyc_t c;
      q.push_back(req_cyc(1'b0, 1'b1, 32'h0005_0000, 32'h5555_AAAA, 32'h0));
      c = req_cyc(1'b0, 1'b1, 32'h0005_0000, 32'h5555_AAAA, 32'h0);
      c.awv = 1'b1; c.awready = 1'b1;
      q.push_back(c);
      c = req_cyc(1'b0, 1'b1, 32'h0005_0000, 32'h5555_AAAA, 32'h0);
      c.wv = 1'b1; c.wstrb = 4'b1111;
      q.push_back(c);
    end
    run_q(1'b0);
    @(negedge clk); #1;
    chk_en = 1'b0;
    chk("rstop_in_W", 32'(WVALID), 32'd1);
    rst = 1'b0;
    apply(base());
    #1;
    m_data_in = '0;
    chk("rstop_WVALID", 32'(WVALID), 32'd0);
    chk("rstop_DM_stall", 32'(DM_stall), 32'd0);
    chk("rstop_Data_in", Data_in, 32'h0);
    chk("rstop_BREADY", 32'(BREADY), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Fresh load after the abandoned store
    add_load(32'h0000_0FFC, 32'hA5A5_5A5A, 2'b00, 1, 0, 0);
    run_q(1'b1);
    chk("post_rst_Data_in", st_data, 32'hA5A5_5A5A);
    chk("post_rst_stall_cycles", 32'(st_stall), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
